// File: rtl/ysyx_23060332_ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer: state codes, reset PC and
// PC step, plus a small alignment helper used by the FSM.
package ysyx_23060332_ctrl_pkg;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t CTRL_IDLE   = 3'd0;
  localparam ctrl_state_t CTRL_FETCH  = 3'd1;
  localparam ctrl_state_t CTRL_DECODE = 3'd2;
  localparam ctrl_state_t CTRL_EXEC   = 3'd3;
  localparam ctrl_state_t CTRL_MEM    = 3'd4;
  localparam ctrl_state_t CTRL_WB     = 3'd5;
  localparam ctrl_state_t CTRL_HALT   = 3'd6;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Instructions are word aligned; any low-bit set in a jump target is fatal.
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter register: async reset to RESET_PC, updated only when load is
// asserted, with the next value chosen between the sequential step and a jump.
module ysyx_23060332_pc_reg
  import ysyx_23060332_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        sel_jump,
  input  logic [31:0] jump_addr,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // The sequential step wraps naturally modulo 2^32.
  assign pc_next = sel_jump ? jump_addr : pc + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ysyx_23060332_ctrl.sv
// Multi-cycle sequencer: steps each instruction through FETCH, DECODE, EXEC,
// optional MEM and WB, owns PC and IR, and halts on ebreak or misaligned jump.
module ysyx_23060332_ctrl
  import ysyx_23060332_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ifu_req,
  output logic [31:0]      ifu_addr,
  input  logic             ifu_rvalid,
  input  logic [31:0]      ifu_rdata,
  output logic [31:0]      inst_o,
  output logic [31:0]      pc_o,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_ebreak,
  input  logic             reg_wen_i,
  input  logic             jump_flag,
  input  logic [31:0]      jump_addr,
  output logic             lsu_req,
  input  logic             lsu_done,
  output logic             rf_we_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] inst_cnt,
  output logic             halt_o,
  output logic             err_o
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  logic        rf_we_q;
  logic        retire_q;
  logic        bad_jump;
  logic        ebreak_retire;

  assign bad_jump      = jump_flag && misaligned(jump_addr);
  assign ebreak_retire = (state == CTRL_DECODE) && is_ebreak;

  always_comb begin
    state_next = state;
    case (state)
      CTRL_IDLE:   state_next = CTRL_FETCH;
      CTRL_FETCH:  if (ifu_rvalid) state_next = CTRL_DECODE;
      CTRL_DECODE: state_next = is_ebreak ? CTRL_HALT : CTRL_EXEC;
      CTRL_EXEC: begin
        if (bad_jump)                 state_next = CTRL_HALT;
        else if (is_load || is_store) state_next = CTRL_MEM;
        else                          state_next = CTRL_WB;
      end
      CTRL_MEM:    if (lsu_done) state_next = CTRL_WB;
      CTRL_WB:     state_next = CTRL_FETCH;
      CTRL_HALT:   state_next = CTRL_HALT;
      default:     state_next = CTRL_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CTRL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_o <= 32'h0;
    end else if ((state == CTRL_FETCH) && ifu_rvalid) begin
      inst_o <= ifu_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (ebreak_retire) begin
        halt_o <= 1'b1;
      end
      if ((state == CTRL_EXEC) && bad_jump) begin
        halt_o <= 1'b1;
        err_o  <= 1'b1;
      end
    end
  end

  // Strobes are registered on entry to WB so they never follow an input
  // combinationally; decoder outputs come from inst_o, which is stable from
  // DECODE onward, so sampling them one cycle early gives the WB-time value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      rf_we_q  <= (state_next == CTRL_WB) && reg_wen_i && !is_store;
      retire_q <= (state_next == CTRL_WB) || ebreak_retire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_cnt <= '0;
    end else if ((state == CTRL_WB) || ebreak_retire) begin
      inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  ysyx_23060332_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CTRL_WB),
    .sel_jump (jump_flag),
    .jump_addr(jump_addr),
    .pc       (pc_o)
  );

  assign ifu_req  = (state == CTRL_FETCH);
  assign lsu_req  = (state == CTRL_MEM);
  assign ifu_addr = pc_o;
  assign rf_we_o  = rf_we_q;
  assign retire_o = retire_q;

endmodule
